// File: rtl/posit_pkg.sv
// Shared definitions for the posit rounding datapath.
// Holds the operand/result widths used by the lanes and the shared round_off
// unit, the arbiter state encoding, and the packed operand/result bundles.
package posit_pkg;

    localparam int unsigned MANT_W = 64;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned K_W    = 6;
    localparam int unsigned EXP_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Operand bundle handed to round_off
    typedef struct packed {
        logic [MANT_W-1:0] mantissa;
        logic [K_W-1:0]    k;
        logic [EXP_W-1:0]  exp;
        logic              sign;
    } ro_operand_t;

    // Rounded bundle returned by round_off
    typedef struct packed {
        logic [OUT_W-1:0] mantissa;
        logic [K_W-1:0]   k;
        logic [EXP_W-1:0] exp;
        logic             sign;
    } ro_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker.
// Searches upward from last_grant+1 (wrapping) and returns the first set
// request.
// Ports:
//   req        in  N      request vector
//   last_grant in  IDX_W  most recently served index
//   grant      out N      one-hot grant (0 when no request)
//   grant_idx  out IDX_W  encoded grant index (0 when no request)
//   any        out 1      at least one request is set
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the N candidates in rotated priority order, keep the first hit
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IDX_W'((32'(last_grant) + off) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign any   = |req;
    assign grant = any ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/round_off_arbiter.sv
// Shares one round_off unit among NUM_REQ posit lanes.
// Accepts one lane's operand bundle at a time (round-robin), sequences the
// round_off start/done handshake and returns the rounded bundle tagged with
// the lane id.
// Optional feature macro: ROUND_ARB_TIMEOUT_EN (WAIT watchdog; on expiry
// round_off is reset for one cycle and an error response is returned).
// Ports:
//   clk, rst                   clock, async active-high reset
//   req_valid/req_ready        per-lane request / one-hot accept pulse
//   req_mantissa/k/exp/sign    flattened lane operands
//   ro_rst_n                   active-low reset to round_off
//   ro_start                   one-cycle start pulse
//   ro_shifted_mantissa/k_out/exp_out/sign_out   latched operands
//   ro_done, ro_*_final, ro_mantissa_out         round_off results
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/mantissa/k/exp/sign result fields, rsp_err watchdog abort flag
module round_off_arbiter
    import posit_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
`ifdef ROUND_ARB_TIMEOUT_EN
    parameter  int unsigned TIMEOUT = 64,
`endif
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MANT_W-1:0] req_mantissa,
    input  logic [NUM_REQ*K_W-1:0]    req_k,
    input  logic [NUM_REQ*EXP_W-1:0]  req_exp,
    input  logic [NUM_REQ-1:0]        req_sign,
    output logic                      ro_rst_n,
    output logic                      ro_start,
    output logic [MANT_W-1:0]         ro_shifted_mantissa,
    output logic [K_W-1:0]            ro_k_out,
    output logic [EXP_W-1:0]          ro_exp_out,
    output logic                      ro_sign_out,
    input  logic                      ro_done,
    input  logic [OUT_W-1:0]          ro_mantissa_out,
    input  logic [K_W-1:0]            ro_k_final,
    input  logic [EXP_W-1:0]          ro_exp_final,
    input  logic                      ro_sign_final,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDX_W-1:0]          rsp_id,
    output logic [OUT_W-1:0]          rsp_mantissa,
    output logic [K_W-1:0]            rsp_k,
    output logic [EXP_W-1:0]          rsp_exp,
    output logic                      rsp_sign,
    output logic                      rsp_err
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    ro_operand_t      op_q;
    ro_result_t       res_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic accept_c;
    logic capture_c;
    logic release_c;
    logic timeout_c;

    ro_operand_t lane_op [NUM_REQ];

    // Unflatten the lane operand buses
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_op[i] = '{
            mantissa: req_mantissa[i*MANT_W +: MANT_W],
            k:        req_k[i*K_W +: K_W],
            exp:      req_exp[i*EXP_W +: EXP_W],
            sign:     req_sign[i]
        };
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ro_done || timeout_c) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / strobe decode; req_ready is combinational from req_valid
    always_comb begin
        req_ready = '0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                accept_c  = arb_any;
                req_ready = arb_grant;
            end
            WAIT:    capture_c = ro_done;
            RESP:    release_c = rsp_ready;
            default: ;
        endcase
    end

    // Operand latch, start pulse, response capture and grant history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            ro_start     <= 1'b0;
            res_q        <= '0;
            rsp_id       <= '0;
            rsp_valid    <= 1'b0;
        end else begin
            ro_start <= accept_c;
            if (accept_c) begin
                op_q        <= lane_op[arb_idx];
                grant_idx_q <= arb_idx;
            end
            if (capture_c) begin
                res_q     <= '{mantissa: ro_mantissa_out, k: ro_k_final,
                               exp: ro_exp_final, sign: ro_sign_final};
                rsp_id    <= grant_idx_q;
                rsp_valid <= 1'b1;
            end else if (timeout_c) begin
                res_q     <= '0;
                rsp_id    <= grant_idx_q;
                rsp_valid <= 1'b1;
            end
            if (release_c) begin
                rsp_valid    <= 1'b0;
                last_grant_q <= grant_idx_q;
            end
        end
    end

    assign ro_shifted_mantissa = op_q.mantissa;
    assign ro_k_out            = op_q.k;
    assign ro_exp_out          = op_q.exp;
    assign ro_sign_out         = op_q.sign;

    assign rsp_mantissa = res_q.mantissa;
    assign rsp_k        = res_q.k;
    assign rsp_exp      = res_q.exp;
    assign rsp_sign     = res_q.sign;

`ifdef ROUND_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             ro_abort_q;
    logic             rsp_err_q;

    // Counts WAIT cycles; zero on the first WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else if (state_q != WAIT) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end

    // Expires after TIMEOUT WAIT cycles without ro_done
    assign timeout_c = (state_q == WAIT) && !ro_done
                       && (wd_cnt_q == CNT_W'(TIMEOUT - 1));

    // One-cycle round_off reset after expiry; error flag held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_abort_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            ro_abort_q <= timeout_c;
            if (timeout_c) begin
                rsp_err_q <= 1'b1;
            end else if (capture_c || release_c) begin
                rsp_err_q <= 1'b0;
            end
        end
    end

    assign ro_rst_n = ~rst & ~ro_abort_q;
    assign rsp_err  = rsp_err_q;
`else
    assign timeout_c = 1'b0;
    assign ro_rst_n  = ~rst;
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_round_off_arbiter.sv
// Self-checking bench for round_off_arbiter. The bench plays the role of
// round_off: a stand-in rounding function supplies results after a random
// latency, and junk is driven on the result bus whenever ro_done is low.
module tb_round_off_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned MW = 64;
    localparam int unsigned OW = 32;
    localparam int unsigned KW = 6;
    localparam int unsigned EW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*MW-1:0]   req_mantissa;
    logic [N*KW-1:0]   req_k;
    logic [N*EW-1:0]   req_exp;
    logic [N-1:0]      req_sign;
    logic              ro_rst_n;
    logic              ro_start;
    logic [MW-1:0]     ro_shifted_mantissa;
    logic [KW-1:0]     ro_k_out;
    logic [EW-1:0]     ro_exp_out;
    logic              ro_sign_out;
    logic              ro_done;
    logic [OW-1:0]     ro_mantissa_out;
    logic [KW-1:0]     ro_k_final;
    logic [EW-1:0]     ro_exp_final;
    logic              ro_sign_final;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [OW-1:0]     rsp_mantissa;
    logic [KW-1:0]     rsp_k;
    logic [EW-1:0]     rsp_exp;
    logic              rsp_sign;
    logic              rsp_err;

    logic [MW-1:0] l_mant [N];
    logic [KW-1:0] l_k    [N];
    logic [EW-1:0] l_exp  [N];
    logic          l_sign [N];

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_mantissa[i*MW +: MW] = l_mant[i];
        assign req_k[i*KW +: KW]        = l_k[i];
        assign req_exp[i*EW +: EW]      = l_exp[i];
        assign req_sign[i]              = l_sign[i];
    end

    round_off_arbiter #(.NUM_REQ(N)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_mantissa        (req_mantissa),
        .req_k               (req_k),
        .req_exp             (req_exp),
        .req_sign            (req_sign),
        .ro_rst_n            (ro_rst_n),
        .ro_start            (ro_start),
        .ro_shifted_mantissa (ro_shifted_mantissa),
        .ro_k_out            (ro_k_out),
        .ro_exp_out          (ro_exp_out),
        .ro_sign_out         (ro_sign_out),
        .ro_done             (ro_done),
        .ro_mantissa_out     (ro_mantissa_out),
        .ro_k_final          (ro_k_final),
        .ro_exp_final        (ro_exp_final),
        .ro_sign_final       (ro_sign_final),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_mantissa        (rsp_mantissa),
        .rsp_k               (rsp_k),
        .rsp_exp             (rsp_exp),
        .rsp_sign            (rsp_sign),
        .rsp_err             (rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int model_last = N - 1;

    // Stand-in rounding: keep the upper half, round half up, saturate
    function automatic logic [OW-1:0] rnd_mant(input logic [MW-1:0] m);
        if (m[63:32] == 32'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return m[63:32] + {31'b0, m[31]};
    endfunction
    function automatic logic [KW-1:0] rnd_k(input logic [MW-1:0] m, input logic [KW-1:0] k);
        return m[31] ? k + 6'd1 : k;
    endfunction
    function automatic logic [EW-1:0] rnd_exp(input logic [MW-1:0] m, input logic [EW-1:0] e);
        return e ^ {1'b0, m[1:0]};
    endfunction

    // Round-robin reference: first valid lane after the last served one
    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic junk_results();
        ro_mantissa_out = $urandom;
        ro_k_final      = 6'($urandom);
        ro_exp_final    = 3'($urandom);
        ro_sign_final   = 1'($urandom);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // One full transaction from accept through response handshake
    task automatic do_txn(input int lat, input int bp, input bit junk_issue, output int lane);
        int waited;
        int el;
        logic [MW-1:0] em;
        logic [KW-1:0] ek;
        logic [EW-1:0] ee;
        logic          es;
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 20) begin
            tick();
            #1;
            waited++;
        end
        check("accept_latency", 64'(waited), 64'd0);
        el = model_pick(req_valid, model_last);
        lane = el;
        if (el < 0) return;
        check("req_ready_onehot", 64'(req_ready), 64'(4'(1) << el));
        em = l_mant[el]; ek = l_k[el]; ee = l_exp[el]; es = l_sign[el];
        tick();
        check("issue_start", 64'(ro_start), 64'd1);
        check("issue_ready", 64'(req_ready), 64'd0);
        check("issue_mant", ro_shifted_mantissa, em);
        check("issue_k", 64'(ro_k_out), 64'(ek));
        check("issue_exp", 64'(ro_exp_out), 64'(ee));
        check("issue_sign", 64'(ro_sign_out), 64'(es));
        if (junk_issue) begin
            ro_done = 1'b1;
            junk_results();
        end
        tick();
        ro_done = 1'b0;
        check("wait_start_low", 64'(ro_start), 64'd0);
        for (int c = 0; c < lat; c++) begin
            check("wait_k_stable", 64'(ro_k_out), 64'(ek));
            check("wait_exp_stable", 64'(ro_exp_out), 64'(ee));
            check("wait_mant_stable", ro_shifted_mantissa, em);
            check("wait_no_rsp", 64'(rsp_valid), 64'd0);
            junk_results();
            tick();
        end
        ro_done         = 1'b1;
        ro_mantissa_out = rnd_mant(em);
        ro_k_final      = rnd_k(em, ek);
        ro_exp_final    = rnd_exp(em, ee);
        ro_sign_final   = es ^ em[2];
        tick();
        ro_done = 1'b0;
        junk_results();
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(el));
        check("rsp_mant", 64'(rsp_mantissa), 64'(rnd_mant(em)));
        check("rsp_k", 64'(rsp_k), 64'(rnd_k(em, ek)));
        check("rsp_exp", 64'(rsp_exp), 64'(rnd_exp(em, ee)));
        check("rsp_sign", 64'(rsp_sign), 64'(es ^ em[2]));
        check("rsp_err", 64'(rsp_err), 64'd0);
        for (int b = 0; b < bp; b++) begin
            tick();
            #1;
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_mant", 64'(rsp_mantissa), 64'(rnd_mant(em)));
            check("bp_id", 64'(rsp_id), 64'(el));
            check("bp_no_accept", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_cleared", 64'(rsp_valid), 64'd0);
        model_last = el;
    endtask

    initial begin
        int lane;
        int order [6];
        order = '{0, 1, 3, 0, 1, 3};
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        ro_done = 1'b0;
        junk_results();
        for (int i = 0; i < N; i++) begin
            l_mant[i] = '0; l_k[i] = '0; l_exp[i] = '0; l_sign[i] = 1'b0;
        end
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_ro_start", 64'(ro_start), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_ro_rst_n", 64'(ro_rst_n), 64'd0);
        check("rst_rsp_mant", 64'(rsp_mantissa), 64'd0);
        check("rst_ro_mant", ro_shifted_mantissa, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_ro_rst_n", 64'(ro_rst_n), 64'd1);

        // Single request on lane 2
        l_mant[2] = 64'hFFFF_FFFF_FFFF_FFFF; l_k[2] = 6'd2; l_exp[2] = 3'd1; l_sign[2] = 1'b0;
        req_valid = 4'b0100;
        do_txn(3, 0, 1'b0, lane);
        check("single_lane", 64'(lane), 64'd2);
        req_valid = '0;
        tick();

        // Lanes 0,1,3 continuously requesting, fresh priority
        apply_reset();
        l_mant[0] = 64'h1234_5678_ABCD_EF01; l_k[0] = 6'd1;  l_exp[0] = 3'd2; l_sign[0] = 1'b0;
        l_mant[1] = 64'hDEAD_BEEF_DEAD_BEEF; l_k[1] = 6'd4;  l_exp[1] = 3'd6; l_sign[1] = 1'b1;
        l_mant[3] = 64'hAAAAAAAA_55555555;   l_k[3] = 6'h3E; l_exp[3] = 3'd0; l_sign[3] = 1'b0;
        req_valid = 4'b1011;
        for (int t = 0; t < 6; t++) begin
            do_txn(1 + t, (t == 2) ? 5 : 0, t == 1, lane);
            check("rr_order", 64'(lane), 64'(order[t]));
        end
        req_valid = '0;
        tick();

        // Negative regime on lane 1
        l_mant[1] = 64'h0F0F_0000_8000_0000; l_k[1] = -6'sd7; l_exp[1] = 3'd5; l_sign[1] = 1'b1;
        req_valid = 4'b0010;
        #1;
        check("negk_operand", 64'(l_k[1]), 64'b111001);
        do_txn(4, 1, 1'b0, lane);
        check("negk_lane", 64'(lane), 64'd1);
        req_valid = '0;
        tick();

        // Random masks, operands, latencies and back-pressure
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                l_mant[i] = {$urandom, $urandom};
                l_k[i]    = 6'($urandom);
                l_exp[i]  = 3'($urandom);
                l_sign[i] = 1'($urandom);
            end
            req_valid = 4'($urandom_range(1, 15));
            do_txn($urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom), lane);
        end
        req_valid = '0;
        tick();

        // Reset asserted in the middle of WAIT
        req_valid = 4'b0010;
        #1;
        check("abort_accept", 64'(req_ready), 64'b0010);
        tick();
        tick();
        tick();
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_ro_start", 64'(ro_start), 64'd0);
        check("abort_ro_mant", ro_shifted_mantissa, 64'd0);
        check("abort_ro_k", 64'(ro_k_out), 64'd0);
        check("abort_ro_rst_n", 64'(ro_rst_n), 64'd0);
        tick();
        rst = 1'b0;
        model_last = N - 1;
        for (int c = 0; c < 4; c++) begin
            ro_done = (c == 1);
            junk_results();
            tick();
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
            check("abort_idle", 64'(req_ready), 64'd0);
        end
        ro_done = 1'b0;
        req_valid = 4'b0101;
        do_txn(2, 0, 1'b0, lane);
        check("post_reset_lane", 64'(lane), 64'd0);
        req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, observed timeout expected finish");
        $fatal(1);
    end

endmodule
